// File: rtl/rpspmc_ad5791_pkg.sv
// Shared AD5791 register map constants and the configuration sequencer state type.
package rpspmc_ad5791_pkg;

  localparam logic [3:0] AD5791_ADDR_NOP     = 4'd0;
  localparam logic [3:0] AD5791_ADDR_DAC     = 4'd1;
  localparam logic [3:0] AD5791_ADDR_CTRL    = 4'd2;
  localparam logic [3:0] AD5791_ADDR_CLRCODE = 4'd3;
  localparam logic [3:0] AD5791_ADDR_SWCTRL  = 4'd4;

  // Control register bit positions (word bits 19:0).
  localparam int AD5791_CTRL_RBUF_BIT    = 1;
  localparam int AD5791_CTRL_OPGND_BIT   = 2;
  localparam int AD5791_CTRL_DACTRI_BIT  = 3;
  localparam int AD5791_CTRL_BIN_BIT     = 4;
  localparam int AD5791_CTRL_SDODIS_BIT  = 5;
  localparam int AD5791_CTRL_LINCOMP_LSB = 6;

  localparam int AD5791_SWCTRL_RESET_BIT = 2;
  localparam logic [23:0] AD5791_SWRESET_WORD = {AD5791_ADDR_SWCTRL, 20'h00004};

  localparam int TMR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_FRAME,
    ST_RELEASE,
    ST_DONE
  } cfg_state_e;

endpackage

// File: rtl/ad5791_cfg_timer.sv
// Loadable down-counter shared by every timed state of the configuration sequencer.
module ad5791_cfg_timer
  import rpspmc_ad5791_pkg::*;
#(
  parameter int CNT_W = TMR_W
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/axis_ad5791_cfg_seq.sv
// Writes one AD5791 register word per enabled channel through the serializer's config port.
// Build option AD5791_SWRESET_FIRST_EN: precede cfg_word with an AD5791 software reset word.
module axis_ad5791_cfg_seq
  import rpspmc_ad5791_pkg::*;
#(
  parameter int NUM_DAC           = 4,
  parameter int DAC_WORD_WIDTH    = 24,
  parameter int SAXIS_TDATA_WIDTH = 32,
  parameter int HOLD_CYCLES       = 8,
  parameter int SEND_CYCLES       = 8,
  parameter int FRAME_CYCLES      = 160
) (
  input  logic                         a_clk,
  input  logic                         a_resetn,
  input  logic                         start,
  input  logic [NUM_DAC-1:0]           axis_mask,
  input  logic [DAC_WORD_WIDTH-1:0]    cfg_word,
  output logic                         busy,
  output logic                         done,
  output logic                         configuration_mode,
  output logic [2:0]                   configuration_axis,
  output logic                         configuration_send,
  output logic [SAXIS_TDATA_WIDTH-1:0] M_AXISCFG_tdata,
  output logic                         M_AXISCFG_tvalid
);

`ifdef AD5791_SWRESET_FIRST_EN
  localparam logic LAST_IDX = 1'b1;
`else
  localparam logic LAST_IDX = 1'b0;
`endif

  localparam logic [TMR_W-1:0] HOLD_VAL  = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] SEND_VAL  = TMR_W'(SEND_CYCLES - 1);
  localparam logic [TMR_W-1:0] FRAME_VAL = TMR_W'(FRAME_CYCLES - 1);

  cfg_state_e                state_q, state_d;
  logic                      start_q;
  logic [NUM_DAC-1:0]        mask_q, mask_d;
  logic [DAC_WORD_WIDTH-1:0] cfg_q, cfg_d;
  logic [2:0]                axis_q, axis_d;
  logic                      idx_q, idx_d;

  logic                      start_rise;
  logic                      tmr_load, tmr_zero;
  logic [TMR_W-1:0]          tmr_val;
  logic [NUM_DAC-1:0]        scan_mask;
  logic                      first_found, next_found;
  logic [2:0]                first_idx, next_idx;
  logic [DAC_WORD_WIDTH-1:0] word_w;

  assign start_rise = start & ~start_q;

  ad5791_cfg_timer #(.CNT_W(TMR_W)) u_timer (
    .clk_i      (a_clk),
    .rst_n_i    (a_resetn),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Lowest set bit overall and lowest set bit above the current axis; descending scan lets the lowest win.
  assign scan_mask = (state_q == ST_IDLE) ? axis_mask : mask_q;

  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = NUM_DAC - 1; i >= 0; i--) begin
      if (scan_mask[i]) begin
        first_found = 1'b1;
        first_idx   = 3'(i);
      end
      if (mask_q[i] && (3'(i) > axis_q)) begin
        next_found = 1'b1;
        next_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    cfg_d    = cfg_q;
    axis_d   = axis_q;
    idx_d    = idx_q;
    tmr_load = 1'b0;
    tmr_val  = HOLD_VAL;
    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          if (first_found) begin
            state_d  = ST_LOAD;
            mask_d   = axis_mask;
            cfg_d    = cfg_word;
            idx_d    = 1'b0;
            axis_d   = first_idx;
            tmr_load = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (next_found) begin
            axis_d = next_idx;
          end else begin
            state_d = ST_SEND;
            tmr_val = SEND_VAL;
          end
        end
      end
      ST_SEND: begin
        if (tmr_zero) begin
          state_d  = ST_FRAME;
          tmr_load = 1'b1;
          tmr_val  = FRAME_VAL;
        end
      end
      ST_FRAME: begin
        // Send is low for the whole wait so the serializer re-arms before any further word.
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (idx_q != LAST_IDX) begin
            state_d = ST_LOAD;
            idx_d   = idx_q + 1'b1;
            axis_d  = first_idx;
          end else begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        if (tmr_zero) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      mask_q  <= '0;
      cfg_q   <= '0;
      axis_q  <= '0;
      idx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      mask_q  <= mask_d;
      cfg_q   <= cfg_d;
      axis_q  <= axis_d;
      idx_q   <= idx_d;
    end
  end

`ifdef AD5791_SWRESET_FIRST_EN
  assign word_w = (idx_q == 1'b0) ? AD5791_SWRESET_WORD : cfg_q;
`else
  assign word_w = cfg_q;
`endif

  assign busy               = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done               = (state_q == ST_DONE);
  assign configuration_mode = busy;
  assign configuration_axis = axis_q;
  assign configuration_send = (state_q == ST_SEND);
  assign M_AXISCFG_tvalid   = (state_q == ST_LOAD);
  assign M_AXISCFG_tdata    = (state_q == ST_LOAD) ?
                              {{(SAXIS_TDATA_WIDTH - DAC_WORD_WIDTH){1'b0}}, word_w} : '0;

endmodule

// File: tb/tb_axis_ad5791_cfg_seq.sv
// Bench for axis_ad5791_cfg_seq with a simple serializer register model and load/frame scoreboards.
module tb_axis_ad5791_cfg_seq;

  localparam int HOLD  = 8;
  localparam int SEND  = 8;
  localparam int FRAME = 160;
`ifdef AD5791_SWRESET_FIRST_EN
  localparam int NW = 2;
`else
  localparam int NW = 1;
`endif

  logic        a_clk = 1'b0;
  logic        a_resetn = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  axis_mask = '0;
  logic [23:0] cfg_word = '0;
  logic        busy, done, configuration_mode, configuration_send, M_AXISCFG_tvalid;
  logic [2:0]  configuration_axis;
  logic [31:0] M_AXISCFG_tdata;

  int errors = 0;
  int checks = 0;

  logic [23:0] ser_ch[4];
  logic [23:0] ref_ch[4];
  logic [26:0] exp_load_q[$];
  logic [95:0] exp_frame_q[$];

  logic        tv_prev = 1'b0, send_prev = 1'b0, done_prev = 1'b0, mode_seen = 1'b0;
  logic [2:0]  axis_prev = '0;
  int          tv_len = 0, send_len = 0, done_cnt = 0;
  logic [26:0] mon_le;
  logic [95:0] mon_fe;

  axis_ad5791_cfg_seq dut (
    .a_clk              (a_clk),
    .a_resetn           (a_resetn),
    .start              (start),
    .axis_mask          (axis_mask),
    .cfg_word           (cfg_word),
    .busy               (busy),
    .done               (done),
    .configuration_mode (configuration_mode),
    .configuration_axis (configuration_axis),
    .configuration_send (configuration_send),
    .M_AXISCFG_tdata    (M_AXISCFG_tdata),
    .M_AXISCFG_tvalid   (M_AXISCFG_tvalid)
  );

  always #4 a_clk = ~a_clk;

  // Serializer model: captures loads, snapshots the four registers on each send rising edge.
  always @(negedge a_clk) begin
    if (!a_resetn) begin
      tv_prev = 1'b0; send_prev = 1'b0; done_prev = 1'b0;
    end else begin
      if (configuration_mode) mode_seen = 1'b1;
      if (M_AXISCFG_tvalid) begin
        if (!tv_prev || configuration_axis != axis_prev) begin
          if (tv_prev) begin
            checks++;
            if (tv_len != HOLD) begin errors++; $display("FAIL load_len got %0d want %0d", tv_len, HOLD); end
          end
          checks++;
          if (exp_load_q.size() == 0) begin
            errors++; $display("FAIL load_unexpected got axis=%0d tdata=%h want none", configuration_axis, M_AXISCFG_tdata);
          end else begin
            mon_le = exp_load_q.pop_front();
            if ({configuration_axis, M_AXISCFG_tdata} !== {mon_le[26:24], 8'h00, mon_le[23:0]}) begin
              errors++; $display("FAIL load got axis=%0d tdata=%h want axis=%0d tdata=%h",
                                 configuration_axis, M_AXISCFG_tdata, mon_le[26:24], {8'h00, mon_le[23:0]});
            end
          end
          tv_len = 1;
        end else begin
          tv_len++;
        end
        if (!configuration_mode) begin
          checks++; errors++; $display("FAIL tvalid_without_mode got mode=0 want 1");
        end
        ser_ch[configuration_axis[1:0]] = M_AXISCFG_tdata[23:0];
      end else if (tv_prev) begin
        checks++;
        if (tv_len != HOLD) begin errors++; $display("FAIL load_len got %0d want %0d", tv_len, HOLD); end
      end
      if (configuration_send && !send_prev) begin
        checks++;
        if (exp_frame_q.size() == 0) begin
          errors++; $display("FAIL frame_unexpected got %h want none", {ser_ch[3], ser_ch[2], ser_ch[1], ser_ch[0]});
        end else begin
          mon_fe = exp_frame_q.pop_front();
          if ({ser_ch[3], ser_ch[2], ser_ch[1], ser_ch[0]} !== mon_fe) begin
            errors++; $display("FAIL frame got %h want %h", {ser_ch[3], ser_ch[2], ser_ch[1], ser_ch[0]}, mon_fe);
          end
        end
        send_len = 1;
      end else if (configuration_send) begin
        send_len++;
      end else if (send_prev) begin
        checks++;
        if (send_len != SEND) begin errors++; $display("FAIL send_len got %0d want %0d", send_len, SEND); end
      end
      if (done) begin
        done_cnt++;
        if (done_prev) begin checks++; errors++; $display("FAIL done_width got 2+ cycles want 1"); end
      end
      tv_prev = M_AXISCFG_tvalid; axis_prev = configuration_axis;
      send_prev = configuration_send; done_prev = done;
    end
  end

  function automatic int exp_latency(input logic [3:0] m);
    return NW * ($countones(m) * HOLD + SEND + FRAME) + HOLD;
  endfunction

  task automatic push_seq(input logic [3:0] m, input logic [23:0] w);
    logic [23:0] words[2];
    words[0] = (NW == 2) ? 24'h400004 : w;
    words[1] = w;
    for (int k = 0; k < NW; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (m[i]) begin
          exp_load_q.push_back({3'(i), words[k]});
          ref_ch[i] = words[k];
        end
      end
      exp_frame_q.push_back({ref_ch[3], ref_ch[2], ref_ch[1], ref_ch[0]});
    end
  endtask

  task automatic run_seq(input logic [3:0] m, input logic [23:0] w, output int lat);
    push_seq(m, w);
    @(negedge a_clk); axis_mask = m; cfg_word = w; start = 1'b1;
    @(posedge a_clk); #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_accept got %b want 1", busy); end
    lat = 0;
    while (done !== 1'b1 && lat < 5000) begin
      @(posedge a_clk); #1; lat++;
    end
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({busy, done, configuration_mode, configuration_send, M_AXISCFG_tvalid} !== 5'b0) begin
      errors++; $display("FAIL %s_ctrl got busy/done/mode/send/tvalid=%b want 00000", tag,
                         {busy, done, configuration_mode, configuration_send, M_AXISCFG_tvalid});
    end
    checks++;
    if (M_AXISCFG_tdata !== 32'h0) begin errors++; $display("FAIL %s_tdata got %h want 0", tag, M_AXISCFG_tdata); end
  endtask

  task automatic check_seq_end(input string tag, input int lat, input int want, input logic [2:0] last_axis);
    checks++;
    if (lat != want) begin errors++; $display("FAIL %s_latency got %0d want %0d", tag, lat, want); end
    @(posedge a_clk); #1;
    check_idle_outputs(tag);
    checks++;
    if (configuration_axis !== last_axis) begin
      errors++; $display("FAIL %s_axis_hold got %0d want %0d", tag, configuration_axis, last_axis);
    end
    checks++;
    if (exp_load_q.size() != 0 || exp_frame_q.size() != 0) begin
      errors++; $display("FAIL %s_pending got loads=%0d frames=%0d want 0/0", tag, exp_load_q.size(), exp_frame_q.size());
    end
  endtask

  task automatic test_reset();
    #3 a_resetn = 1'b0;
    repeat (3) @(posedge a_clk);
    #1 check_idle_outputs("reset_held");
    checks++;
    if (configuration_axis !== 3'd0) begin errors++; $display("FAIL reset_axis got %0d want 0", configuration_axis); end
    @(negedge a_clk) a_resetn = 1'b1;
    @(posedge a_clk); #1;
    check_idle_outputs("reset_release");
  endtask

  task automatic test_full_mask();
    int lat;
    run_seq(4'b1111, 24'h200012, lat);
    check_seq_end("full", lat, exp_latency(4'b1111), 3'd3);
  endtask

  task automatic test_partial_mask();
    int lat;
    ser_ch[1] = 24'h0A5A5A; ref_ch[1] = 24'h0A5A5A;
    ser_ch[3] = 24'h012345; ref_ch[3] = 24'h012345;
    run_seq(4'b0101, 24'h200002, lat);
    check_seq_end("partial", lat, exp_latency(4'b0101), 3'd2);
  endtask

  task automatic test_reset_mid_frame();
    int lat;
    push_seq(4'b1111, 24'h200012);
    @(negedge a_clk); axis_mask = 4'b1111; cfg_word = 24'h200012; start = 1'b1;
    @(posedge a_clk); #1 start = 1'b0;
    repeat (60) @(posedge a_clk);
    @(negedge a_clk); #2 a_resetn = 1'b0;
    #1;
    checks++;
    if ({configuration_mode, configuration_send, M_AXISCFG_tvalid, busy} !== 4'b0) begin
      errors++; $display("FAIL midreset got mode/send/tvalid/busy=%b want 0000",
                         {configuration_mode, configuration_send, M_AXISCFG_tvalid, busy});
    end
    exp_load_q.delete(); exp_frame_q.delete();
    repeat (3) @(negedge a_clk);
    a_resetn = 1'b1;
    run_seq(4'b1111, 24'h200012, lat);
    check_seq_end("after_reset", lat, exp_latency(4'b1111), 3'd3);
  endtask

  task automatic test_back_to_back();
    int lat, d0;
    d0 = done_cnt;
    push_seq(4'b0011, 24'h200012);
    @(negedge a_clk); axis_mask = 4'b0011; cfg_word = 24'h200012; start = 1'b1;
    @(posedge a_clk); #1 start = 1'b0;
    repeat (50) @(posedge a_clk);
    @(negedge a_clk); axis_mask = 4'b1000; cfg_word = 24'h3FFFFF; start = 1'b1;
    @(negedge a_clk); start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 5000) begin @(posedge a_clk); #1; lat++; end
    checks++;
    if (lat >= 5000) begin errors++; $display("FAIL b2b_timeout got %0d cycles want done", lat); end
    repeat (300) @(posedge a_clk);
    #1;
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL b2b_done_count got %0d want 1", done_cnt - d0); end
    check_idle_outputs("b2b_end");
  endtask

  task automatic test_start_held();
    int d0;
    d0 = done_cnt;
    push_seq(4'b1001, 24'h200012);
    @(negedge a_clk); axis_mask = 4'b1001; cfg_word = 24'h200012; start = 1'b1;
    repeat (1000) @(posedge a_clk);
    @(negedge a_clk); start = 1'b0;
    repeat (10) @(posedge a_clk);
    #1;
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL held_done_count got %0d want 1", done_cnt - d0); end
    checks++;
    if (exp_load_q.size() != 0 || exp_frame_q.size() != 0) begin
      errors++; $display("FAIL held_pending got loads=%0d frames=%0d want 0/0", exp_load_q.size(), exp_frame_q.size());
    end
  endtask

  task automatic test_mask_zero();
    int d0, n;
    d0 = done_cnt;
    @(negedge a_clk); mode_seen = 1'b0; axis_mask = 4'b0000; cfg_word = 24'h200012; start = 1'b1;
    n = 0;
    do begin @(posedge a_clk); #1; n++; end while (done !== 1'b1 && n < 2);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL mask0_done got %b want 1 within 2 cycles", done); end
    checks++;
    if (busy !== 1'b0 || configuration_mode !== 1'b0) begin
      errors++; $display("FAIL mask0_busy_mode got busy=%b mode=%b want 0/0", busy, configuration_mode);
    end
    start = 1'b0;
    repeat (5) @(posedge a_clk);
    #1;
    checks++;
    if (mode_seen !== 1'b0) begin errors++; $display("FAIL mask0_mode_seen got %b want 0", mode_seen); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL mask0_done_count got %0d want 1", done_cnt - d0); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin ser_ch[i] = 24'h0; ref_ch[i] = 24'h0; end
    test_reset();
    test_full_mask();
    test_partial_mask();
    test_reset_mid_frame();
    test_back_to_back();
    test_start_held();
    test_mask_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
